// File: rtl/stg_2_id.sv
// Instruction-decode stage: 16-entry register file with writeback bypass,
// load-use hazard detection, ID/EX pipeline registers and halt state.
module stg_2_id #(
    parameter int unsigned INSTR_W      = 32,
    parameter int unsigned INSTR_ADDR_W = 10,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned REG_ADDR_W   = 4
) (
    input  logic                    sys_clock,
    input  logic                    reset_n,
    input  logic [INSTR_W-1:0]      i_id_instr,
    input  logic [INSTR_ADDR_W-1:0] i_id_pc,
    input  logic                    i_flush,
    input  logic                    i_wb_we,
    input  logic [REG_ADDR_W-1:0]   i_wb_rd,
    input  logic [DATA_W-1:0]       i_wb_data,
    output logic                    o_stall,
    output logic                    o_halted,
    output logic                    r_ex_valid,
    output logic [3:0]              r_ex_op,
    output logic [REG_ADDR_W-1:0]   r_ex_rd,
    output logic [REG_ADDR_W-1:0]   r_ex_rs1,
    output logic [REG_ADDR_W-1:0]   r_ex_rs2,
    output logic [DATA_W-1:0]       r_ex_a,
    output logic [DATA_W-1:0]       r_ex_b,
    output logic [DATA_W-1:0]       r_ex_imm,
    output logic [INSTR_ADDR_W-1:0] r_ex_pc
);

    localparam int unsigned NREGS = 2 ** REG_ADDR_W;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_ADDI = 4'h5,
        OP_LD   = 4'h6,
        OP_ST   = 4'h7,
        OP_BEQ  = 4'h8,
        OP_JMP  = 4'h9,
        OP_HALT = 4'hF
    } opcode_t;

    typedef enum logic {
        S_RUN,
        S_HALTED
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] rf_q [NREGS];

    logic                    ex_valid_q, ex_valid_d;
    logic [3:0]              ex_op_q, ex_op_d;
    logic [REG_ADDR_W-1:0]   ex_rd_q, ex_rd_d;
    logic [REG_ADDR_W-1:0]   ex_rs1_q, ex_rs1_d;
    logic [REG_ADDR_W-1:0]   ex_rs2_q, ex_rs2_d;
    logic [DATA_W-1:0]       ex_a_q, ex_a_d;
    logic [DATA_W-1:0]       ex_b_q, ex_b_d;
    logic [DATA_W-1:0]       ex_imm_q, ex_imm_d;
    logic [INSTR_ADDR_W-1:0] ex_pc_q, ex_pc_d;

    logic [3:0]            op;
    logic [REG_ADDR_W-1:0] rd, rs1, rs2;
    logic [DATA_W-1:0]     imm;
    logic [DATA_W-1:0]     opnd_a, opnd_b;
    logic                  uses_rs2, legal, hazard, accept;

    assign op  = i_id_instr[31:28];
    assign rd  = i_id_instr[27:24];
    assign rs1 = i_id_instr[23:20];
    assign rs2 = i_id_instr[19:16];
    assign imm = i_id_instr[15:0];

    // NOP is folded into the illegal set so it always produces a bubble.
    always_comb begin
        uses_rs2 = 1'b0;
        legal    = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ST, OP_BEQ: begin
                uses_rs2 = 1'b1;
                legal    = 1'b1;
            end
            OP_ADDI, OP_LD, OP_JMP, OP_HALT: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    // Same-cycle writeback bypass; r0 never bypasses and is never written.
    always_comb begin
        opnd_a = rf_q[rs1];
        opnd_b = rf_q[rs2];
        if (i_wb_we && (rs1 != '0) && (i_wb_rd == rs1)) opnd_a = i_wb_data;
        if (i_wb_we && (rs2 != '0) && (i_wb_rd == rs2)) opnd_b = i_wb_data;
    end

    always_comb begin
        hazard = ex_valid_q && (ex_op_q == OP_LD) && (ex_rd_q != '0) &&
                 ((ex_rd_q == rs1) || (uses_rs2 && (ex_rd_q == rs2)));
        accept = (state_q == S_RUN) && !i_flush && !hazard;
    end

    always_comb begin
        state_d    = state_q;
        ex_valid_d = 1'b0;
        ex_op_d    = '0;
        ex_rd_d    = '0;
        ex_rs1_d   = '0;
        ex_rs2_d   = '0;
        ex_a_d     = '0;
        ex_b_d     = '0;
        ex_imm_d   = '0;
        ex_pc_d    = '0;
        o_stall    = 1'b0;
        o_halted   = 1'b0;
        case (state_q)
            S_RUN: begin
                o_stall = hazard && !i_flush;
                if (accept && legal) begin
                    ex_valid_d = 1'b1;
                    ex_op_d    = op;
                    ex_rd_d    = rd;
                    ex_rs1_d   = rs1;
                    ex_rs2_d   = rs2;
                    ex_a_d     = opnd_a;
                    ex_b_d     = opnd_b;
                    ex_imm_d   = imm;
                    ex_pc_d    = i_id_pc;
                    if (op == OP_HALT) state_d = S_HALTED;
                end
            end
            S_HALTED: begin
                o_stall  = 1'b1;
                o_halted = 1'b1;
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_RUN;
            ex_valid_q <= 1'b0;
            ex_op_q    <= '0;
            ex_rd_q    <= '0;
            ex_rs1_q   <= '0;
            ex_rs2_q   <= '0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            ex_imm_q   <= '0;
            ex_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            ex_valid_q <= ex_valid_d;
            ex_op_q    <= ex_op_d;
            ex_rd_q    <= ex_rd_d;
            ex_rs1_q   <= ex_rs1_d;
            ex_rs2_q   <= ex_rs2_d;
            ex_a_q     <= ex_a_d;
            ex_b_q     <= ex_b_d;
            ex_imm_q   <= ex_imm_d;
            ex_pc_q    <= ex_pc_d;
        end
    end

    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else if (i_wb_we && (i_wb_rd != '0)) begin
            rf_q[i_wb_rd] <= i_wb_data;
        end
    end

    assign r_ex_valid = ex_valid_q;
    assign r_ex_op    = ex_op_q;
    assign r_ex_rd    = ex_rd_q;
    assign r_ex_rs1   = ex_rs1_q;
    assign r_ex_rs2   = ex_rs2_q;
    assign r_ex_a     = ex_a_q;
    assign r_ex_b     = ex_b_q;
    assign r_ex_imm   = ex_imm_q;
    assign r_ex_pc    = ex_pc_q;

endmodule
